mux_dwell_sequencer: RTL and testbench
======================================

# mux_dwell_sequencer

Command-driven sequencer that sits directly upstream of the dwell down-counter in the multiplexer path. It accepts one (channel, dwell) command at a time, drives the mux channel select, loads the dwell value into the downstream counter, generates that counter's clock-enable tick from a prescaler, and waits for the counter's busy flag to fall. It then pulses `done` and returns to idle.

## Interface
- `WIDTH`, default 3: dwell width. Equals the downstream counter width.
- `CHAN_WIDTH`, default 4: channel select width.
- `PRESCALE`, default 8: clock cycles per counter tick. Must be ≥1.
- `SETTLE_CYCLES`, default 2: settle delay in clock cycles. Must be ≥1. Used only with `MUX_SETTLE_EN`.

- `CLK`  in  1  single clock; all logic on posedge.
- `RST`  in  1  synchronous, active-high reset.
- `cmdValid`  in  1  command offered.
- `cmdReady`  out  1  sequencer can accept a command.
- `cmdChannel`  in  CHAN_WIDTH  channel to select.
- `cmdDwell`  in  WIDTH  dwell in ticks.
- `cntBusy`  in  1  busy flag from the downstream counter.
- `cntData`  out  WIDTH  load value to the counter.
- `cntLoad`  out  1  one-cycle load strobe to the counter.
- `cntEnable`  out  1  tick (clock-enable) to the counter.
- `muxChannel`  out  CHAN_WIDTH  selected channel.
- `muxEnable`  out  1  mux output enable.
- `done`  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, SELECT, SETTLE (only with macro), LOAD, WAIT, DONE. Outputs are decoded from registered state and registered data only; no input-to-output combinational path.
- IDLE:
  - `cmdReady`=1.
  - On `cmdValid`&&`cmdReady`, capture `cmdChannel` into `muxChannel` and `cmdDwell` into `cntData`, then go to SELECT.
- SELECT: `muxEnable`=1. Go to SETTLE if the macro is defined, otherwise to LOAD.
- SETTLE: stay `SETTLE_CYCLES` cycles, counted by the prescaler counter, then go to LOAD.
- LOAD:
  - `cntLoad`=1 for exactly one cycle.
  - Prescaler cleared to 0.
  - Go to WAIT.
- WAIT:
  - Prescaler counts 0..PRESCALE-1 and wraps.
  - `cntEnable`=1 exactly when prescaler == PRESCALE-1. With PRESCALE=1, `cntEnable` is constant 1 in WAIT.
  - When `cntBusy`==0, go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `muxEnable`: 1 in SELECT through DONE; 0 in IDLE.
- `muxChannel` and `cntData` hold their last captured values in IDLE.
- `cntEnable`: 0 outside WAIT.
- Prescaler width: clog2(max(PRESCALE, SETTLE_CYCLES)), minimum 1 bit.
- Commands are ignored while `cmdReady`=0. There is no queueing and no dropped-command flag.
- `cmdDwell`=0 is legal. The counter is loaded with 0, busy is already low in the first WAIT cycle, and `done` follows immediately.
- Reset values, held while `RST`=1:
  - state = IDLE.
  - `cmdReady`=0 during reset, 1 in the first cycle after release.
  - All other outputs 0.
  - Prescaler 0.
- `RST` asserted in any state aborts the operation. The next cycle is IDLE with outputs at reset values, and `done` does not fire.

## Timing
- Command accepted in cycle N, macro undefined:
  - SELECT at N+1 (`muxChannel`/`muxEnable` valid).
  - LOAD at N+2.
  - WAIT from N+3; the counter shows busy from N+3.
  - `cntEnable` pulses at N+3+k·P+(P−1), for k=0..D−1.
  - `done` at N+4+D·P.
- With `MUX_SETTLE_EN`, every event from LOAD onward shifts by `SETTLE_CYCLES`.
- Next accept is possible no earlier than the cycle after `done`. Minimum command spacing is 5+D·P cycles (plus `SETTLE_CYCLES` with the macro).

## Configuration
- `MUX_SETTLE_EN` defined:
  - SETTLE state is built in.
  - The mux is selected and held enabled for `SETTLE_CYCLES` cycles before the counter is loaded.
- `MUX_SETTLE_EN` undefined:
  - No SETTLE state; SELECT goes directly to LOAD.
  - `SETTLE_CYCLES` is unused.

## Test plan
- Reset: hold `RST` 3 cycles → all outputs 0. After release, `cmdReady`=1 in the first cycle.
- Nominal run (PRESCALE=4, D=3, ch=5, macro off, accept at N), downstream counter modelled:
  - N+1: `muxChannel`=5, `muxEnable`=1.
  - N+2: `cntLoad`=1, `cntData`=3.
  - `cntEnable` at N+6, N+10, N+14.
  - `done` at N+16.
  - `muxEnable` back to 0 at N+17.
- Zero dwell (D=0, PRESCALE=4, accept at N) → `cntLoad` at N+2, no `cntEnable` pulse, `done` at N+4.
- Back-to-back: `cmdValid` held high with two commands → second accepted only in the cycle after the first `done`. Second command's `muxChannel` appears one cycle later.
- Abort: `RST` pulsed in WAIT (D=7) → next cycle IDLE, `muxEnable`=0, no `done`. A new command then completes normally.
- `MUX_SETTLE_EN` with SETTLE_CYCLES=2, PRESCALE=4, D=3 → `cntLoad` at N+4, `done` at N+18.

Source files
------------

// File: rtl/mux_dwell_sequencer.sv
// mux_dwell_sequencer
// Accepts one (channel, dwell) command at a time, selects the mux channel,
// loads the downstream dwell down-counter, ticks it from a prescaler and
// waits for its busy flag to fall before pulsing done.
// Build option: define MUX_SETTLE_EN to insert a SETTLE state that holds the
// freshly selected mux for SETTLE_CYCLES before the counter is loaded.
// Outputs come only from registered state and registered data, so there is
// no combinational path from any input to any output.
module mux_dwell_sequencer #(
  parameter int WIDTH         = 3,
  parameter int CHAN_WIDTH    = 4,
  parameter int PRESCALE      = 8,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  cmdValid,
  output logic                  cmdReady,
  input  logic [CHAN_WIDTH-1:0] cmdChannel,
  input  logic [WIDTH-1:0]      cmdDwell,
  input  logic                  cntBusy,
  output logic [WIDTH-1:0]      cntData,
  output logic                  cntLoad,
  output logic                  cntEnable,
  output logic [CHAN_WIDTH-1:0] muxChannel,
  output logic                  muxEnable,
  output logic                  done
);

  // One shared counter serves both the settle delay and the tick prescaler,
  // so it is sized for whichever of the two needs the larger range.
  localparam int PRE_MAX = (PRESCALE > SETTLE_CYCLES) ? PRESCALE : SETTLE_CYCLES;
  localparam int PW      = (PRE_MAX > 1) ? $clog2(PRE_MAX) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
`ifdef MUX_SETTLE_EN
  localparam logic [PW-1:0] SETTLE_LAST = PW'(SETTLE_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
`ifdef MUX_SETTLE_EN
    SETTLE = 3'd2,
`endif
    LOAD   = 3'd3,
    WAIT   = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t                state;
  logic [PW-1:0]         presc;
  logic                  ready_q;
  logic [CHAN_WIDTH-1:0] channel_q;
  logic [WIDTH-1:0]      dwell_q;

  // Sequencer FSM together with its prescaler, ready flag and captured command.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      presc     <= '0;
      ready_q   <= 1'b0;
      channel_q <= '0;
      dwell_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmdValid && ready_q) begin
            channel_q <= cmdChannel;
            dwell_q   <= cmdDwell;
            ready_q   <= 1'b0;
            state     <= SELECT;
          end else begin
            ready_q   <= 1'b1;
          end
        end
        SELECT: begin
          presc <= '0;
`ifdef MUX_SETTLE_EN
          state <= SETTLE;
`else
          state <= LOAD;
`endif
        end
`ifdef MUX_SETTLE_EN
        SETTLE: begin
          if (presc == SETTLE_LAST) begin
            presc <= '0;
            state <= LOAD;
          end else begin
            presc <= presc + 1'b1;
          end
        end
`endif
        LOAD: begin
          presc <= '0;
          state <= WAIT;
        end
        WAIT: begin
          presc <= (presc == PRE_LAST) ? '0 : presc + 1'b1;
          if (!cntBusy) begin
            state <= DONE;
          end
        end
        DONE: begin
          ready_q <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          presc   <= '0;
          ready_q <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign cmdReady   = ready_q;
  assign cntData    = dwell_q;
  assign muxChannel = channel_q;
  assign muxEnable  = (state != IDLE);
  assign cntLoad    = (state == LOAD);
  assign cntEnable  = (state == WAIT) && (presc == PRE_LAST);
  assign done       = (state == DONE);

endmodule

// File: tb/tb_mux_dwell_sequencer.sv
// tb_mux_dwell_sequencer
// Directed bench for mux_dwell_sequencer with a modelled downstream dwell
// counter. A timeline model (offsets from the accept cycle) predicts every
// output each cycle; literal event times pin the model for the key scenarios.
// Honours MUX_SETTLE_EN by shifting events from LOAD onward.
module tb_mux_dwell_sequencer;

  localparam int WIDTH         = 3;
  localparam int CHAN_WIDTH    = 4;
  localparam int PRESCALE      = 4;
  localparam int SETTLE_CYCLES = 2;
`ifdef MUX_SETTLE_EN
  localparam int SOFF = SETTLE_CYCLES;
`else
  localparam int SOFF = 0;
`endif

  logic                  CLK = 1'b0;
  logic                  RST = 1'b1;
  logic                  cmdValid = 1'b0;
  logic [CHAN_WIDTH-1:0] cmdChannel = '0;
  logic [WIDTH-1:0]      cmdDwell = '0;
  logic                  cmdReady;
  logic                  cntBusy;
  logic [WIDTH-1:0]      cntData;
  logic                  cntLoad;
  logic                  cntEnable;
  logic [CHAN_WIDTH-1:0] muxChannel;
  logic                  muxEnable;
  logic                  done;

  logic [WIDTH-1:0] cnt_model = '0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_q[$];
  int done_q[$];
  int load_q[$];
  int en_q[$];

  bit rst_s, val_s, dut_rdy_prev, prev_rdy;
  int ch_s, dw_s;
  bit m_live = 1'b0;
  bit m_active = 1'b0;
  bit m_rdy = 1'b0;
  int m_t0, m_dw, m_ch, m_data, t, wait_len;
  int e_en, e_load, e_done;

  mux_dwell_sequencer #(
    .WIDTH(WIDTH),
    .CHAN_WIDTH(CHAN_WIDTH),
    .PRESCALE(PRESCALE),
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .cmdValid(cmdValid),
    .cmdReady(cmdReady),
    .cmdChannel(cmdChannel),
    .cmdDwell(cmdDwell),
    .cntBusy(cntBusy),
    .cntData(cntData),
    .cntLoad(cntLoad),
    .cntEnable(cntEnable),
    .muxChannel(muxChannel),
    .muxEnable(muxEnable),
    .done(done)
  );

  // Free-running clock.
  always #5 CLK = ~CLK;

  // Downstream dwell down-counter: load on strobe, decrement on each tick.
  always @(posedge CLK) begin
    if (RST) cnt_model <= '0;
    else if (cntLoad) cnt_model <= cntData;
    else if (cntEnable && cnt_model != 0) cnt_model <= cnt_model - 1'b1;
  end
  assign cntBusy = (cnt_model != 0);

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Timeline model and per-cycle comparison, sampled 1 time unit after each edge.
  always @(posedge CLK) begin
    rst_s = RST;
    val_s = cmdValid;
    ch_s  = int'(cmdChannel);
    dw_s  = int'(cmdDwell);
    if (dut_rdy_prev && val_s && !rst_s) acc_q.push_back(cyc);
    cyc++;
    #1;
    if (rst_s) begin
      m_live   = 1'b1;
      m_active = 1'b0;
      m_rdy    = 1'b0;
      m_ch     = 0;
      m_data   = 0;
    end else if (m_live) begin
      prev_rdy = m_rdy;
      if (m_active && (cyc - 1) == m_t0 + 4 + SOFF + m_dw * PRESCALE) m_active = 1'b0;
      if (!m_active && prev_rdy && val_s) begin
        m_active = 1'b1;
        m_t0     = cyc - 1;
        m_dw     = dw_s;
        m_ch     = ch_s;
        m_data   = dw_s;
      end
      m_rdy = !m_active;
    end
    if (m_live) begin
      t        = cyc - m_t0;
      wait_len = m_dw * PRESCALE;
      e_load   = (m_active && t == 2 + SOFF) ? 1 : 0;
      e_done   = (m_active && t == 4 + SOFF + wait_len) ? 1 : 0;
      e_en     = (m_active && t >= 3 + SOFF && t < 3 + SOFF + wait_len &&
                  ((t - 3 - SOFF) % PRESCALE) == PRESCALE - 1) ? 1 : 0;
      checkOutput("cmdReady",   int'(cmdReady),   m_rdy ? 1 : 0);
      checkOutput("muxEnable",  int'(muxEnable),  m_active ? 1 : 0);
      checkOutput("muxChannel", int'(muxChannel), m_ch);
      checkOutput("cntData",    int'(cntData),    m_data);
      checkOutput("cntLoad",    int'(cntLoad),    e_load);
      checkOutput("cntEnable",  int'(cntEnable),  e_en);
      checkOutput("done",       int'(done),       e_done);
    end
    dut_rdy_prev = cmdReady;
    if (done)      done_q.push_back(cyc);
    if (cntLoad)   load_q.push_back(cyc);
    if (cntEnable) en_q.push_back(cyc);
  end

  task automatic clearLogs();
    acc_q.delete();
    done_q.delete();
    load_q.delete();
    en_q.delete();
  endtask

  task automatic waitReady();
    int n = 0;
    while (!cmdReady && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (!cmdReady) checkOutput("ready_timeout", 0, 1);
  endtask

  task automatic waitDone();
    int n = 0;
    while (!done && n < 300) begin
      @(negedge CLK);
      n++;
    end
    if (!done) checkOutput("done_timeout", 0, 1);
    @(negedge CLK);
  endtask

  task automatic applyStimulus(input int ch, input int dw, input bit wait_done);
    clearLogs();
    waitReady();
    cmdValid   = 1'b1;
    cmdChannel = CHAN_WIDTH'(ch);
    cmdDwell   = WIDTH'(dw);
    @(negedge CLK);
    cmdValid = 1'b0;
    if (wait_done) waitDone();
  endtask

  // Directed scenarios with literal event-time expectations.
  initial begin
    int n;
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    checkOutput("reset_cmdReady",  int'(cmdReady), 0);
    checkOutput("reset_muxEnable", int'(muxEnable), 0);
    checkOutput("reset_cntLoad",   int'(cntLoad), 0);
    checkOutput("reset_done",      int'(done), 0);
    checkOutput("reset_muxChannel", int'(muxChannel), 0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    checkOutput("release_cmdReady", int'(cmdReady), 1);

    // Nominal: channel 5, dwell 3.
    applyStimulus(5, 3, 1);
    checkOutput("nominal_accepts", acc_q.size(), 1);
    n = (acc_q.size() > 0) ? acc_q[0] : -1000;
    checkOutput("nominal_loads", load_q.size(), 1);
    if (load_q.size() > 0) checkOutput("nominal_load_cycle", load_q[0] - n, 2 + SOFF);
    checkOutput("nominal_ticks", en_q.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < en_q.size()) checkOutput("nominal_tick_cycle", en_q[i] - n, 6 + SOFF + 4 * i);
    checkOutput("nominal_dones", done_q.size(), 1);
    if (done_q.size() > 0) checkOutput("nominal_done_cycle", done_q[0] - n, 16 + SOFF);

    // Zero dwell: channel 9, dwell 0.
    applyStimulus(9, 0, 1);
    n = (acc_q.size() > 0) ? acc_q[0] : -1000;
    if (load_q.size() > 0) checkOutput("zero_load_cycle", load_q[0] - n, 2 + SOFF);
    checkOutput("zero_ticks", en_q.size(), 0);
    checkOutput("zero_dones", done_q.size(), 1);
    if (done_q.size() > 0) checkOutput("zero_done_cycle", done_q[0] - n, 4 + SOFF);

    // Back-to-back: valid held high across two commands.
    clearLogs();
    waitReady();
    cmdValid   = 1'b1;
    cmdChannel = 4'd2;
    cmdDwell   = 3'd1;
    @(negedge CLK);
    cmdChannel = 4'd11;
    cmdDwell   = 3'd2;
    waitReady();
    @(negedge CLK);
    cmdValid = 1'b0;
    waitDone();
    checkOutput("b2b_accepts", acc_q.size(), 2);
    checkOutput("b2b_dones", done_q.size(), 2);
    if (acc_q.size() >= 2 && done_q.size() >= 1) begin
      checkOutput("b2b_accept_after_done", acc_q[1] - done_q[0], 1);
      checkOutput("b2b_spacing", acc_q[1] - acc_q[0], 9 + SOFF);
    end

    // Abort: reset pulsed during WAIT with dwell 7, then a fresh command.
    applyStimulus(3, 7, 0);
    repeat (5) @(negedge CLK);
    checkOutput("abort_pre_muxEnable", int'(muxEnable), 1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    checkOutput("abort_muxEnable", int'(muxEnable), 0);
    checkOutput("abort_cmdReady", int'(cmdReady), 0);
    checkOutput("abort_muxChannel", int'(muxChannel), 0);
    repeat (3) @(negedge CLK);
    checkOutput("abort_no_done", done_q.size(), 0);
    applyStimulus(6, 2, 1);
    n = (acc_q.size() > 0) ? acc_q[0] : -1000;
    checkOutput("post_abort_dones", done_q.size(), 1);
    if (done_q.size() > 0) checkOutput("post_abort_done_cycle", done_q[0] - n, 12 + SOFF);

    repeat (2) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop in case the run stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
